// File: rtl/modbus_pkg.sv
// modbus_pkg: shared states and constants for the Modbus RTU transmit framer
package modbus_pkg;
  typedef enum logic [2:0] {IDLE, POP, LOAD, SEND, CRC_LO, CRC_HI, DRAIN, GAP} state_t;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;
  localparam int MAX_LEN = 254;
endpackage

// File: rtl/modbus_tx_framer_if.sv
// modbus_tx_framer_if: request, FIFO read, UART and status signals of the framer
interface modbus_tx_framer_if;
  logic start;
  logic [7:0] len;
  logic fifo_empty;
  logic [7:0] fifo_r_q;
  logic fifo_r_v;
  logic [7:0] tx_d;
  logic tx_v;
  logic tx_rdy;
  logic uart_idle;
  logic busy;
  logic done;
  logic err;
  modport master (
    output start, len, fifo_empty, fifo_r_q, tx_rdy, uart_idle,
    input fifo_r_v, tx_d, tx_v, busy, done, err
  );
  modport slave (
    input start, len, fifo_empty, fifo_r_q, tx_rdy, uart_idle,
    output fifo_r_v, tx_d, tx_v, busy, done, err
  );
endinterface

// File: rtl/modbus_crc16.sv
// modbus_crc16: one-byte Modbus CRC-16 update, LSB first, reflected polynomial
module modbus_crc16
  import modbus_pkg::*;
(
  input logic [15:0] crc_in,
  input logic [7:0] din,
  output logic [15:0] crc_out
);
  always_comb begin
    crc_out = crc_in ^ {8'h00, din};
    for (int i = 0; i < 8; i++) crc_out = crc_out[0] ? (crc_out >> 1) ^ CRC_POLY : crc_out >> 1;
  end
endmodule

// File: rtl/modbus_tx_framer.sv
// modbus_tx_framer: pops payload bytes from a FIFO, sends them plus CRC-16 to a UART, then enforces the inter-frame gap
module modbus_tx_framer #(
  parameter int GAP_CYCLES = 100260,
  parameter int MAX_LEN = modbus_pkg::MAX_LEN
) (
  input logic clk,
  input logic rst_n,
  modbus_tx_framer_if.slave bus
);
  import modbus_pkg::*;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  state_t state, state_n;
  logic [15:0] crc, crc_n, crc_upd;
  logic [7:0] rem, rem_n, tx_d_n;
  logic [GW-1:0] gap, gap_n;
  logic done_n, err_n, hs, legal;
  assign hs = bus.tx_v & bus.tx_rdy;
  assign legal = bus.len != 8'd0 && {24'd0, bus.len} <= 32'(MAX_LEN);
  assign bus.fifo_r_v = state == POP && !bus.fifo_empty;
  assign bus.tx_v = state inside {SEND, CRC_LO, CRC_HI};
  assign bus.busy = state != IDLE;
  modbus_crc16 u_crc (.crc_in(crc), .din(bus.fifo_r_q), .crc_out(crc_upd));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      crc <= CRC_INIT;
      rem <= '0;
      gap <= '0;
      bus.tx_d <= '0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      state <= state_n;
      crc <= crc_n;
      rem <= rem_n;
      gap <= gap_n;
      bus.tx_d <= tx_d_n;
      bus.done <= done_n;
      bus.err <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    crc_n = crc;
    rem_n = rem;
    gap_n = gap;
    tx_d_n = bus.tx_d;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_n = legal ? POP : IDLE;
        crc_n = legal ? CRC_INIT : crc;
        rem_n = legal ? bus.len : rem;
        err_n = !legal;
      end
      POP: state_n = bus.fifo_empty ? POP : LOAD;
      LOAD: begin
        tx_d_n = bus.fifo_r_q;
        crc_n = crc_upd;
        state_n = SEND;
      end
      SEND: if (hs) begin
        rem_n = rem - 8'd1;
        state_n = rem == 8'd1 ? CRC_LO : POP;
        tx_d_n = rem == 8'd1 ? crc[7:0] : bus.tx_d;
      end
      CRC_LO: if (hs) begin
        state_n = CRC_HI;
        tx_d_n = crc[15:8];
      end
      CRC_HI: state_n = hs ? DRAIN : CRC_HI;
      DRAIN: if (bus.uart_idle) begin
        gap_n = '0;
        state_n = GAP;
      end
      GAP: begin
        gap_n = gap + GW'(1);
        state_n = gap == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
        done_n = gap == GW'(GAP_CYCLES - 1);
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
